multicycle_controller: RTL and testbench

Multicycle sequencing controller for the 19-bit SCMIPS datapath. It holds a fetch/decode/execute/memory/writeback state machine and steps one shared memory port and one ALU through each instruction over several cycles. It also keeps registered Z/C flags for conditional branches and tracks call-stack depth for JSB/RET. It drives the same control strobes the datapath already consumes, plus PC/IR write enables and the memory address select.

---
 rtl/scmips_ctrl_pkg.sv | 49 ++++
 rtl/instr_class_decode.sv | 28 ++
 rtl/multicycle_controller.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scmips_ctrl_pkg.sv
// Shared types and constants for the SCMIPS multicycle controller.
package scmips_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StFault  = 3'd6
  } state_e;

  // ClsMemNone is a memory-format opcode whose sub-op ([15:14] = 10/11) performs no access.
  typedef enum logic [3:0] {
    ClsAluR,
    ClsAluI,
    ClsShift,
    ClsLoad,
    ClsStore,
    ClsMemNone,
    ClsBranch,
    ClsJump,
    ClsJsb,
    ClsRet,
    ClsHalt,
    ClsNop
  } instr_class_e;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_STACK  = 2'b10;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b11;

  localparam logic [18:0] HALT_WORD = 19'h7FFFF;

  // BZ / BNZ / BC / BNC evaluated against the registered flags.
  function automatic logic branch_taken(input logic [1:0] cond, input logic z, input logic c);
    logic taken;
    case (cond)
      2'b00:   taken = z;
      2'b01:   taken = ~z;
      2'b10:   taken = c;
      default: taken = ~c;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: instruction[18:13] -> instruction class.
// The full-word HALT check is done by the caller, since it needs all 19 bits.
module instr_class_decode
  import scmips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  output instr_class_e cls_o
);

  // Opcode prefix match; anything not listed is a no-op.
  always_comb begin
    cls_o = ClsNop;
    casez (opcode_i)
      6'b00????: cls_o = ClsAluR;
      6'b01????: cls_o = ClsAluI;
      6'b10000?: cls_o = ClsLoad;
      6'b10001?: cls_o = ClsStore;
      6'b1001??: cls_o = ClsMemNone;
      6'b101???: cls_o = ClsBranch;
      6'b110???: cls_o = ClsShift;
      6'b11100?: cls_o = ClsJump;
      6'b11101?: cls_o = ClsJsb;
      6'b111100: cls_o = ClsRet;
      default:   cls_o = ClsNop;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 19-bit SCMIPS datapath.
// Optional feature: define MEMORY_WAIT_HANDSHAKE_EN to stall FETCH and MEM on mem_ready.
module multicycle_controller
  import scmips_ctrl_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] instruction,
  input  logic        zero,
  input  logic        carry,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_en,
  output logic        mem_read_write,
  output logic        reg_write_signal,
  output logic        reg2_read_source,
  output logic        mem_or_alu,
  output logic        alu_src,
  output logic        is_shift,
  output logic        update_z_c,
  output logic [2:0]  acode,
  output logic [1:0]  scode,
  output logic [1:0]  pc_src,
  output logic        stack_push,
  output logic        stack_pop,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  state_e          state_q, state_d;
  instr_class_e    cls_dec, cls_d, cls_q;
  logic [2:0]      fld_q;
  logic [SpW-1:0]  sp_q, sp_d;
  logic            z_q, c_q;
  logic            ready;

`ifdef MEMORY_WAIT_HANDSHAKE_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign ready            = 1'b1;
  assign unused_mem_ready = mem_ready;
`endif

  instr_class_decode u_decode (
    .opcode_i (instruction[18:13]),
    .cls_o    (cls_dec)
  );

  assign cls_d = (instruction == HALT_WORD) ? ClsHalt : cls_dec;
  assign state = state_q;

  // State, latched class/fields, return-stack depth and Z/C flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      cls_q   <= ClsNop;
      fld_q   <= '0;
      sp_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      if (state_q == StDecode) begin
        cls_q <= cls_d;
        fld_q <= instruction[16:14];
      end
      if (update_z_c) begin
        z_q <= zero;
        c_q <= carry;
      end
    end
  end

  // Next state and Moore control outputs; everything is forced low while rst is high.
  always_comb begin
    state_d          = state_q;
    sp_d             = sp_q;
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    iord             = 1'b0;
    mem_en           = 1'b0;
    mem_read_write   = 1'b0;
    reg_write_signal = 1'b0;
    reg2_read_source = 1'b0;
    mem_or_alu       = 1'b0;
    alu_src          = 1'b0;
    is_shift         = 1'b0;
    update_z_c       = 1'b0;
    acode            = '0;
    scode            = '0;
    pc_src           = PC_SRC_INC;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    halted           = 1'b0;
    fault            = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_en = 1'b1;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: state_d = (cls_d == ClsHalt) ? StHalt : StExec;
      StExec: begin
        state_d = StFetch;
        case (cls_q)
          ClsAluR, ClsAluI: begin
            acode      = fld_q;
            alu_src    = (cls_q == ClsAluI);
            update_z_c = 1'b1;
            state_d    = StWb;
          end
          ClsShift: begin
            is_shift   = 1'b1;
            scode      = fld_q[1:0];
            update_z_c = 1'b1;
            state_d    = StWb;
          end
          ClsLoad, ClsStore, ClsMemNone: begin
            alu_src          = 1'b1;
            reg2_read_source = 1'b1;
            state_d          = StMem;
          end
          ClsBranch: begin
            if (branch_taken(fld_q[1:0], z_q, c_q)) begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_BRANCH;
            end
          end
          ClsJump: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
          end
          ClsJsb: begin
            if (sp_q == SpW'(STACK_DEPTH)) begin
              state_d = StFault;
            end else begin
              pc_write   = 1'b1;
              pc_src     = PC_SRC_JUMP;
              stack_push = 1'b1;
              sp_d       = sp_q + SpW'(1);
            end
          end
          ClsRet: begin
            if (sp_q == '0) begin
              state_d = StFault;
            end else begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_STACK;
              stack_pop = 1'b1;
              sp_d      = sp_q - SpW'(1);
            end
          end
          default: ;
        endcase
      end
      StMem: begin
        iord             = 1'b1;
        reg2_read_source = 1'b1;
        state_d          = StFetch;
        case (cls_q)
          ClsLoad: begin
            mem_en  = 1'b1;
            state_d = ready ? StWb : StMem;
          end
          ClsStore: begin
            mem_en         = 1'b1;
            mem_read_write = 1'b1;
            state_d        = ready ? StFetch : StMem;
          end
          default: ;
        endcase
      end
      StWb: begin
        reg_write_signal = 1'b1;
        mem_or_alu       = (cls_q != ClsLoad);
        state_d          = StFetch;
      end
      StHalt:  halted = 1'b1;
      StFault: fault = 1'b1;
      default: state_d = StFetch;
    endcase

    if (rst) begin
      pc_write         = 1'b0;
      ir_write         = 1'b0;
      iord             = 1'b0;
      mem_en           = 1'b0;
      mem_read_write   = 1'b0;
      reg_write_signal = 1'b0;
      reg2_read_source = 1'b0;
      alu_src          = 1'b0;
      is_shift         = 1'b0;
      update_z_c       = 1'b0;
      stack_push       = 1'b0;
      stack_pop        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: every expected per-cycle output record is queued when an instruction is
// issued and compared against the DUT on the falling edge.
module tb_multicycle_controller;

  localparam int unsigned DEPTH = 2;
  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4;
  localparam logic [2:0] SH = 3'd5, SX = 3'd6;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_en, iord, rw, ir_wr, pc_wr;
    logic [1:0] pc_src;
    logic       reg_wr, moa, alu_src, r2rs, is_shift, uzc;
    logic [2:0] acode;
    logic [1:0] scode;
    logic       push, pop, halted, fault;
  } obs_t;

  logic        clk, rst, zero, carry, mem_ready;
  logic [18:0] instruction;
  logic        pc_write, ir_write, iord, mem_en, mem_read_write, reg_write_signal;
  logic        reg2_read_source, mem_or_alu, alu_src, is_shift, update_z_c;
  logic [2:0]  acode, state;
  logic [1:0]  scode, pc_src;
  logic        stack_push, stack_pop, halted, fault;

  obs_t        sb_q[$];
  obs_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          step = 0;
  logic        model_z, model_c;
  int          model_sp;

  multicycle_controller #(.STACK_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .instruction      (instruction),
    .zero             (zero),
    .carry            (carry),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .ir_write         (ir_write),
    .iord             (iord),
    .mem_en           (mem_en),
    .mem_read_write   (mem_read_write),
    .reg_write_signal (reg_write_signal),
    .reg2_read_source (reg2_read_source),
    .mem_or_alu       (mem_or_alu),
    .alu_src          (alu_src),
    .is_shift         (is_shift),
    .update_z_c       (update_z_c),
    .acode            (acode),
    .scode            (scode),
    .pc_src           (pc_src),
    .stack_push       (stack_push),
    .stack_pop        (stack_pop),
    .halted           (halted),
    .fault            (fault),
    .state            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cur = {state, mem_en, iord, mem_read_write, ir_write, pc_write, pc_src,
                reg_write_signal, mem_or_alu, alu_src, reg2_read_source, is_shift, update_z_c,
                acode, scode, stack_push, stack_pop, halted, fault};

  // Scoreboard comparator.
  always @(negedge clk) begin
    obs_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      step++;
      checks++;
      if (cur !== e) begin
        errors++;
        $display("FAIL step %0d: got %h required %h", step, cur, e);
      end
    end
  end

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  // Reference model of one instruction; leaves model flags/depth updated.
  task automatic expect_instr(input logic [18:0] ins, input logic zin, input logic cin);
    obs_t e;
    logic taken;
    e = blank(SF); e.mem_en = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
    sb_q.push_back(e);
    sb_q.push_back(blank(SD));
    if (ins == 19'h7FFFF) begin
      e = blank(SH); e.halted = 1'b1;
      repeat (3) sb_q.push_back(e);
      return;
    end
    e = blank(SE);
    casez (ins[18:13])
      6'b0?????: begin
        e.acode = ins[16:14]; e.alu_src = ins[17]; e.uzc = 1'b1;
        sb_q.push_back(e);
        model_z = zin; model_c = cin;
        e = blank(SW); e.reg_wr = 1'b1; e.moa = 1'b1;
        sb_q.push_back(e);
      end
      6'b110???: begin
        e.is_shift = 1'b1; e.scode = ins[15:14]; e.uzc = 1'b1;
        sb_q.push_back(e);
        model_z = zin; model_c = cin;
        e = blank(SW); e.reg_wr = 1'b1; e.moa = 1'b1;
        sb_q.push_back(e);
      end
      6'b100???: begin
        e.alu_src = 1'b1; e.r2rs = 1'b1;
        sb_q.push_back(e);
        e = blank(SM); e.iord = 1'b1; e.r2rs = 1'b1;
        if (ins[15:14] == 2'b00) begin
          e.mem_en = 1'b1;
          sb_q.push_back(e);
          e = blank(SW); e.reg_wr = 1'b1;
          sb_q.push_back(e);
        end else begin
          e.mem_en = (ins[15:14] == 2'b01);
          e.rw     = (ins[15:14] == 2'b01);
          sb_q.push_back(e);
        end
      end
      6'b101???: begin
        case (ins[15:14])
          2'b00:   taken = model_z;
          2'b01:   taken = ~model_z;
          2'b10:   taken = model_c;
          default: taken = ~model_c;
        endcase
        if (taken) begin e.pc_wr = 1'b1; e.pc_src = 2'b11; end
        sb_q.push_back(e);
      end
      6'b11100?: begin
        e.pc_wr = 1'b1; e.pc_src = 2'b01;
        sb_q.push_back(e);
      end
      6'b11101?, 6'b111100: begin
        if ((ins[14] && model_sp == DEPTH) || (!ins[14] && model_sp == 0)) begin
          sb_q.push_back(e);
          e = blank(SX); e.fault = 1'b1;
          repeat (3) sb_q.push_back(e);
        end else begin
          e.pc_wr  = 1'b1;
          e.pc_src = ins[14] ? 2'b01 : 2'b10;
          e.push   = ins[14];
          e.pop    = ~ins[14];
          model_sp = ins[14] ? model_sp + 1 : model_sp - 1;
          sb_q.push_back(e);
        end
      end
      default: sb_q.push_back(e);
    endcase
  endtask

  // Wait (bounded) for the scoreboard to empty, then step into the next FETCH cycle.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, required 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [18:0] ins, input logic zin, input logic cin);
    instruction = ins; zero = zin; carry = cin;
    expect_instr(ins, zin, cin);
    drain();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (state !== SF) begin
      errors++; $display("FAIL reset_state: got %0d required %0d", state, SF);
    end
    checks++;
    if ({mem_en, ir_write, pc_write, reg_write_signal, stack_push, stack_pop, update_z_c} !== 7'b0)
    begin
      errors++; $display("FAIL reset_strobes: got %b required 0000000",
        {mem_en, ir_write, pc_write, reg_write_signal, stack_push, stack_pop, update_z_c});
    end
    checks++;
    if ({halted, fault} !== 2'b00) begin
      errors++; $display("FAIL reset_status: got %b required 00", {halted, fault});
    end
    model_z = 1'b0; model_c = 1'b0; model_sp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_alu();
    issue({2'b00, 3'b010, 14'd0}, 1'b0, 1'b0);
    issue({2'b01, 3'b011, 14'h1234}, 1'b0, 1'b1);
  endtask

  task automatic test_load_store();
    issue({3'b100, 2'b00, 14'h0042}, 1'b0, 1'b0);
    issue({3'b100, 2'b01, 14'h0042}, 1'b0, 1'b0);
    issue({3'b100, 2'b10, 14'h0007}, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    issue({2'b01, 3'b000, 14'd5}, 1'b1, 1'b0);     // Z=1
    issue({3'b101, 2'b00, 14'd9}, 1'b0, 1'b1);     // BZ taken on registered Z
    issue({3'b101, 2'b01, 14'd9}, 1'b0, 1'b1);     // BNZ not taken
    issue({3'b110, 1'b0, 2'b11, 13'd0}, 1'b0, 1'b1); // shift: Z=0, C=1
    issue({3'b101, 2'b00, 14'd9}, 1'b1, 1'b0);     // BZ not taken
    issue({3'b101, 2'b10, 14'd9}, 1'b0, 1'b0);     // BC taken
    issue({3'b101, 2'b11, 14'd9}, 1'b0, 1'b0);     // BNC not taken
    issue({2'b00, 3'b001, 14'd0}, 1'b0, 1'b0);
    issue({3'b101, 2'b01, 14'd9}, 1'b1, 1'b1);     // BNZ taken
  endtask

  task automatic test_jump_nop();
    issue({5'b11100, 14'h0100}, 1'b0, 1'b0);
    issue({6'b111101, 13'd0}, 1'b0, 1'b0);
  endtask

  task automatic test_stack();
    issue({5'b11101, 14'h0010}, 1'b0, 1'b0);
    issue({6'b111100, 13'd0}, 1'b0, 1'b0);
    issue({5'b11101, 14'h0010}, 1'b0, 1'b0);
    issue({5'b11101, 14'h0020}, 1'b0, 1'b0);
    issue({5'b11101, 14'h0030}, 1'b0, 1'b0);       // depth full -> FAULT
    test_reset();
    issue({6'b111100, 13'd0}, 1'b0, 1'b0);         // empty -> FAULT
    test_reset();
  endtask

  task automatic test_halt();
    issue(19'h7FFFF, 1'b0, 1'b0);
    checks++;
    if ({halted, mem_en, pc_write, ir_write} !== 4'b1000) begin
      errors++; $display("FAIL halt_sticky: got %b required 1000",
        {halted, mem_en, pc_write, ir_write});
    end
    test_reset();
  endtask

  task automatic test_reset_mid();
    obs_t e;
    instruction = {3'b100, 2'b00, 14'h0003};
    e = blank(SF); e.mem_en = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
    sb_q.push_back(e);
    sb_q.push_back(blank(SD));
    e = blank(SE); e.alu_src = 1'b1; e.r2rs = 1'b1;
    sb_q.push_back(e);
    drain();
    checks++;
    if ({state, mem_en} !== {SM, 1'b1}) begin
      errors++; $display("FAIL mid_in_mem: got %0d/%b required %0d/1", state, mem_en, SM);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({state, mem_en, iord, reg_write_signal} !== {SF, 3'b000}) begin
      errors++; $display("FAIL mid_reset: got %0d/%b required %0d/000", state,
        {mem_en, iord, reg_write_signal}, SF);
    end
    model_z = 1'b0; model_c = 1'b0; model_sp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    issue({3'b101, 2'b00, 14'd9}, 1'b1, 1'b1);     // Z cleared by reset: BZ not taken
  endtask

`ifdef MEMORY_WAIT_HANDSHAKE_EN
  task automatic test_mem_wait();
    obs_t e;
    instruction = {2'b01, 3'b001, 14'd3};
    zero = 1'b0; carry = 1'b1;
    mem_ready = 1'b0;
    e = blank(SF); e.mem_en = 1'b1;
    repeat (3) sb_q.push_back(e);
    expect_instr(instruction, zero, carry);
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    drain();
  endtask
`endif

  initial begin
    rst = 1'b1; zero = 1'b0; carry = 1'b0; instruction = '0;
`ifdef MEMORY_WAIT_HANDSHAKE_EN
    mem_ready = 1'b1;
`else
    mem_ready = 1'b0;
`endif
    model_z = 1'b0; model_c = 1'b0; model_sp = 0;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jump_nop();
    test_stack();
    test_halt();
    test_reset_mid();
`ifdef MEMORY_WAIT_HANDSHAKE_EN
    test_mem_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
